// File: rtl/mmcm_drp_sequencer.sv
// MMCM run-time reconfiguration: holds the MMCM in reset, applies masked DRP
// read-modify-writes from a cfg stream, then releases reset and waits for lock.
module mmcm_drp_sequencer #(
    parameter int unsigned RST_CYCLES   = 8,
    parameter int unsigned DRDY_TIMEOUT = 255,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [6:0]  cfg_addr,
    input  logic [15:0] cfg_mask,
    input  logic [15:0] cfg_data,
    input  logic        cfg_last,
    output logic [6:0]  drp_addr,
    output logic        drp_en,
    output logic        drp_we,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_rdy,
    output logic        mmcm_rst,
    input  logic        mmcm_locked,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);

    localparam int unsigned MaxA   = (RST_CYCLES > DRDY_TIMEOUT) ? RST_CYCLES : DRDY_TIMEOUT;
    localparam int unsigned CntMax = (MaxA > LOCK_TIMEOUT) ? MaxA : LOCK_TIMEOUT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [3:0] {
        StIdle, StAssertRst, StWaitEntry, StRd, StRdWait, StWr, StWrWait,
        StRelease, StWaitLock, StDone, StError
    } state_t;

    state_t            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [6:0]        addr_q, addr_d;
    logic [15:0]       mask_q, mask_d;
    logic [15:0]       data_q, data_d;
    logic              last_q, last_d;
    logic [15:0]       di_q, di_d;
    logic              rst_q, rst_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [1:0]        code_q, code_d;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            di_q    <= '0;
            rst_q   <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            last_q  <= last_d;
            di_q    <= di_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            error_q <= error_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        addr_d    = addr_q;
        mask_d    = mask_q;
        data_d    = data_q;
        last_d    = last_q;
        di_d      = di_q;
        error_d   = error_q;
        code_d    = code_q;
        cfg_ready = 1'b0;
        drp_en    = 1'b0;
        drp_we    = 1'b0;

        case (state_q)
            StIdle: begin
                if (cfg_valid) begin
                    state_d = StAssertRst;
                    error_d = 1'b0;
                    code_d  = 2'd0;
                end
            end
            StAssertRst: begin
                if (cnt_q == CntW'(RST_CYCLES - 1)) state_d = StWaitEntry;
            end
            StWaitEntry: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    // drp_addr moves on the same edge the read strobe rises
                    addr_d  = cfg_addr;
                    mask_d  = cfg_mask;
                    data_d  = cfg_data;
                    last_d  = cfg_last;
                    state_d = StRd;
                end
            end
            StRd: begin
                drp_en  = 1'b1;
                state_d = StRdWait;
            end
            StRdWait: begin
                if (drp_rdy) begin
                    di_d    = (drp_do & ~mask_q) | (data_q & mask_q);
                    state_d = StWr;
                end else if (cnt_q == CntW'(DRDY_TIMEOUT)) begin
                    state_d = StError;
                    code_d  = 2'd1;
                end
            end
            StWr: begin
                drp_en  = 1'b1;
                drp_we  = 1'b1;
                state_d = StWrWait;
            end
            StWrWait: begin
                if (drp_rdy) begin
                    state_d = last_q ? StRelease : StWaitEntry;
                end else if (cnt_q == CntW'(DRDY_TIMEOUT)) begin
                    state_d = StError;
                    code_d  = 2'd1;
                end
            end
            StRelease: state_d = StWaitLock;
            StWaitLock: begin
                if (mmcm_locked) begin
                    state_d = StDone;
                end else if (cnt_q == CntW'(LOCK_TIMEOUT)) begin
                    state_d = StError;
                    code_d  = 2'd2;
                end
            end
            StDone:  state_d = StIdle;
            StError: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // every wait/count state starts from zero on entry
        if (state_d != state_q) cnt_d = '0;
        if (state_d == StError) error_d = 1'b1;

        // registered from next state so mmcm_rst and done are glitch-free
        rst_d  = (state_d == StAssertRst) || (state_d == StWaitEntry) || (state_d == StRd) ||
                 (state_d == StRdWait) || (state_d == StWr) || (state_d == StWrWait);
        done_d = (state_d == StDone) || (state_d == StError);
    end

    assign drp_addr = addr_q;
    assign drp_di   = di_q;
    assign mmcm_rst = rst_q;
    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign error    = error_q;
    assign err_code = code_q;

endmodule
